q_path_walker: RTL and testbench

Q_PATH_WALKER -- requirements
Module: q_path_walker

---
 rtl/q_path_walker.sv | 171 +++++++++++++++++
 tb/tb_q_path_walker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/q_path_walker.sv
// Greedy Q-table maze walker: from start_state, repeatedly takes the legal move with the highest Q value until it reaches the target or gives up.
// Each step takes two cycles (EVAL, MOVE). Optional loop abort with `define WALK_LOOP_DETECT_EN.
module q_path_walker #(
  parameter int GRID_W    = 6,
  parameter int MAX_STEPS = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] q_table [0:GRID_W*GRID_W][0:3],
  input  logic        start,
  input  logic [5:0]  start_state,
  input  logic [5:0]  target_state,
  output logic        busy,
  output logic [5:0]  cur_state,
  output logic        step_valid,
  output logic [1:0]  step_dir,
  output logic [5:0]  step_count,
  output logic        done,
  output logic        fail
);

  localparam int         NS   = GRID_W * GRID_W;
  localparam logic [5:0] GW6  = 6'(GRID_W);
  localparam logic [5:0] GWM1 = 6'(GRID_W - 1);
  localparam logic [5:0] NS6  = 6'(NS);
  localparam logic [5:0] TOP6 = 6'(NS - GRID_W);
  localparam logic [5:0] MAX6 = 6'(MAX_STEPS);

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_MOVE, S_DONE, S_FAIL} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cur_q, cur_d;
  logic [5:0]  tgt_q, tgt_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic [5:0]  nxt_q, nxt_d;

  logic        cur_ok, tgt_ok;
  logic [5:0]  col;
  logic [3:0]  legal;
  logic [5:0]  nb [4];
  logic [31:0] best_val;
  logic [1:0]  best_dir;
  logic        best_ok;
  logic        revisit;

`ifdef WALK_LOOP_DETECT_EN
  logic [NS-1:0] vis_q, vis_d;
  logic [NS-1:0] start_hot, nxt_hot;

  always_comb begin
    start_hot = '0;
    nxt_hot   = '0;
    for (int i = 0; i < NS; i++) begin
      start_hot[i] = (start_state == 6'(i + 1));
      nxt_hot[i]   = (nxt_q == 6'(i + 1));
    end
  end

  always_comb begin
    vis_d = vis_q;
    if (start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL))
      vis_d = start_hot;
    else if (state_q == S_MOVE)
      vis_d = vis_q | nxt_hot;
  end

  assign revisit = |(vis_q & nxt_hot);

  always_ff @(posedge clk) begin
    if (rst) vis_q <= '0;
    else     vis_q <= vis_d;
  end
`else
  assign revisit = 1'b0;
`endif

  // Legality is derived from the 1-based state number's row and column.
  always_comb begin
    cur_ok   = (cur_q != 6'd0) && (cur_q <= NS6);
    tgt_ok   = (tgt_q != 6'd0) && (tgt_q <= NS6);
    col      = (cur_q - 6'd1) % GW6;
    legal[0] = cur_ok && (cur_q <= TOP6);
    legal[1] = cur_ok && (col != GWM1);
    legal[2] = cur_ok && (cur_q > GW6);
    legal[3] = cur_ok && (col != 6'd0);
    nb[0]    = cur_q + GW6;
    nb[1]    = cur_q + 6'd1;
    nb[2]    = cur_q - GW6;
    nb[3]    = cur_q - 6'd1;
  end

  // Strict compare keeps the lowest-indexed direction on ties.
  always_comb begin
    best_val = '0;
    best_dir = '0;
    best_ok  = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (legal[d] && (!best_ok || q_table[cur_q][d] > best_val)) begin
        best_ok  = 1'b1;
        best_val = q_table[cur_q][d];
        best_dir = 2'(d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= '0;
      nxt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      nxt_q   <= nxt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    nxt_d   = nxt_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          cur_d   = start_state;
          tgt_d   = target_state;
          cnt_d   = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!cur_ok || !tgt_ok)                state_d = S_FAIL;
        else if (cur_q == tgt_q)               state_d = S_DONE;
        else if (cnt_q == MAX6)                state_d = S_FAIL;
        else if (!best_ok || best_val == '0)   state_d = S_FAIL;
        else begin
          dir_d   = best_dir;
          nxt_d   = nb[best_dir];
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        cur_d   = nxt_q;
        cnt_d   = cnt_q + 6'd1;
        state_d = revisit ? S_FAIL : S_EVAL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_EVAL) || (state_q == S_MOVE);
    step_valid = (state_q == S_MOVE) && !rst;
    done       = (state_q == S_DONE);
    fail       = (state_q == S_FAIL);
    cur_state  = cur_q;
    step_count = cnt_q;
    step_dir   = dir_q;
  end

endmodule

// File: tb/tb_q_path_walker.sv
`timescale 1ns/1ps
module tb_q_path_walker;
  localparam int G  = 6;
  localparam int NS = 36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  start_state = '0;
  logic [5:0]  target_state = '0;
  logic [31:0] q [0:NS][0:3];
  logic        busy, step_valid, done, fail;
  logic [5:0]  cur_state, step_count;
  logic [1:0]  step_dir;

  int errors = 0;
  int checks = 0;

  int exp_dirs[$];
  int exp_states[$];
  int exp_cur, exp_cnt;
  bit exp_done, exp_fail;

  always #5 clk = ~clk;

  q_path_walker #(.GRID_W(G), .MAX_STEPS(36)) dut (
    .clk(clk), .rst(rst), .q_table(q), .start(start),
    .start_state(start_state), .target_state(target_state),
    .busy(busy), .cur_state(cur_state), .step_valid(step_valid),
    .step_dir(step_dir), .step_count(step_count), .done(done), .fail(fail)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic zero_q();
    for (int s = 0; s <= NS; s++)
      for (int d = 0; d < 4; d++) q[s][d] = '0;
  endtask

  // Reference: grid coordinates (row, col) and a plain greedy walk.
  task automatic model_walk(input int s, input int t);
    int  cur, r, c, nr, nc, bd;
    longint best;
    bit  vis [1:36];
    bit  fin;
    int  dr [4] = '{1, 0, -1, 0};
    int  dc [4] = '{0, 1, 0, -1};
    exp_dirs.delete();
    exp_states.delete();
    exp_done = 0;
    exp_fail = 0;
    exp_cur  = s;
    exp_cnt  = 0;
    if (s < 1 || s > NS || t < 1 || t > NS) begin
      exp_fail = 1;
    end else begin
      for (int i = 1; i <= NS; i++) vis[i] = 0;
      cur = s;
      vis[s] = 1;
      fin = 0;
      while (!fin) begin
        if (cur == t) begin
          exp_done = 1; fin = 1;
        end else if (exp_dirs.size() == 36) begin
          exp_fail = 1; fin = 1;
        end else begin
          r = (cur - 1) / G;
          c = (cur - 1) % G;
          best = -1;
          bd = 0;
          for (int d = 0; d < 4; d++) begin
            nr = r + dr[d];
            nc = c + dc[d];
            if (nr >= 0 && nr < G && nc >= 0 && nc < G && longint'(q[cur][d]) > best) begin
              best = longint'(q[cur][d]);
              bd = d;
            end
          end
          if (best <= 0) begin
            exp_fail = 1; fin = 1;
          end else begin
            cur = (r + dr[bd]) * G + (c + dc[bd]) + 1;
            exp_dirs.push_back(bd);
            exp_states.push_back(cur);
`ifdef WALK_LOOP_DETECT_EN
            if (vis[cur]) begin
              exp_fail = 1; fin = 1;
            end
`endif
            vis[cur] = 1;
          end
        end
      end
      exp_cur = cur;
      exp_cnt = exp_dirs.size();
    end
  endtask

  task automatic run_walk(input string tag, input int s, input int t);
    int k, cyc;
    bit pend;
    model_walk(s, t);
    start_state  = 6'(s);
    target_state = 6'(t);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; cyc = 0; pend = 0;
    while (busy && cyc < 300) begin
      if (step_valid) begin
        if (k < exp_dirs.size()) chk({tag, "_dir"}, 32'(step_dir), 32'(exp_dirs[k]));
        k++;
        pend = 1;
      end
      tick();
      cyc++;
      if (pend) begin
        if (k <= exp_states.size()) chk({tag, "_pos"}, 32'(cur_state), 32'(exp_states[k-1]));
        pend = 0;
      end
    end
    chk({tag, "_timeout"}, 32'(busy), 0);
    chk({tag, "_pulses"}, k, exp_dirs.size());
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_fail"}, 32'(fail), 32'(exp_fail));
    chk({tag, "_cnt"}, 32'(step_count), exp_cnt);
    chk({tag, "_cur"}, 32'(cur_state), exp_cur);
    chk({tag, "_sv_idle"}, 32'(step_valid), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_cur"}, 32'(cur_state), 0);
    chk({tag, "_sv"}, 32'(step_valid), 0);
    chk({tag, "_dir"}, 32'(step_dir), 0);
    chk({tag, "_cnt"}, 32'(step_count), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
  endtask

  initial begin
    int n, cyc;
    zero_q();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("reset");

    // E, N, N from 1 to 14
    zero_q();
    q[1][1] = 5; q[2][0] = 5; q[8][0] = 5;
    run_walk("path3", 1, 14);
    chk("path3_cnt_const", 32'(step_count), 3);

    run_walk("self", 20, 20);
    chk("self_cnt_const", 32'(step_count), 0);

    // S excluded at state 1; N wins the 7/7 tie with E
    zero_q();
    q[1][0] = 7; q[1][1] = 7; q[1][2] = 9; q[1][3] = 0;
    run_walk("tie", 1, 7);
    chk("tie_cur_const", 32'(cur_state), 7);

    zero_q();
    run_walk("dead", 5, 36);

    zero_q();
    q[1][1] = 3; q[2][3] = 3;
    run_walk("loop", 1, 36);
`ifdef WALK_LOOP_DETECT_EN
    chk("loop_cnt_const", 32'(step_count), 2);
`else
    chk("loop_cnt_const", 32'(step_count), 36);
`endif

    run_walk("bad_start", 0, 10);
    run_walk("bad_tgt", 3, 40);

    // Reset in the middle of a walk, during the second step's MOVE cycle
    zero_q();
    q[1][1] = 5; q[2][0] = 5; q[8][0] = 5;
    start_state = 6'd1; target_state = 6'd14;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      if (step_valid) n++;
      if (n < 2) begin
        tick();
        cyc++;
      end
    end
    chk("mid_wait", n, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_sv", 32'(step_valid), 0);
    tick();
    rst = 1'b0;
    chk_all_zero("mid_rst");
    run_walk("after_rst", 1, 14);

    for (int it = 0; it < 10; it++) begin
      for (int s = 1; s <= NS; s++)
        for (int d = 0; d < 4; d++)
          q[s][d] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
      run_walk("rand", int'($urandom_range(1, 36)), int'($urandom_range(1, 36)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
